alu_arbiter: RTL and testbench

Shares one combinational 32-bit ALU (op map 000 ADD, 001 AND, 010 OR, 011 XOR) between two requesters. Each requester submits an operand/op transaction over a valid/ready handshake. The arbiter grants round-robin, registers the operands into the ALU, captures Result/Zero one cycle later, and returns them on a single tagged response channel. It sits between the requesters and the ALU instance; the ALU stays outside this block.

---
 rtl/alu_arbiter.sv | 126 ++++++++++++
 tb/tb_alu_arbiter.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Round-robin front end that shares one external combinational ALU between two
// requesters, registering operands in and returning a tagged, held response.
module alu_arbiter #(
  parameter int WIDTH   = 32,
  parameter int NUM_OPS = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       ReqValid,
  output logic [1:0]       ReqReady,
  input  logic [WIDTH-1:0] ReqA0,
  input  logic [WIDTH-1:0] ReqB0,
  input  logic [2:0]       ReqOp0,
  input  logic [WIDTH-1:0] ReqA1,
  input  logic [WIDTH-1:0] ReqB1,
  input  logic [2:0]       ReqOp1,
  output logic [WIDTH-1:0] AluA,
  output logic [WIDTH-1:0] AluB,
  output logic [2:0]       AluControl,
  input  logic [WIDTH-1:0] AluResult,
  input  logic             AluZero,
  output logic             RspValid,
  input  logic             RspReady,
  output logic             RspId,
  output logic [WIDTH-1:0] Result,
  output logic             Zero,
  output logic             RspErr,
  output logic             Busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} stateT;

  stateT            state, nextState;
  logic             lastGrant;
  logic             grant;
  logic             anyValid;
  logic             err;
  logic             illegalOp;
  logic [WIDTH-1:0] selA, selB;
  logic [2:0]       selOp;

  // Arbitration and operand selection for the current IDLE cycle.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    anyValid = |ReqValid;
    grant    = 1'b0;
    ReqReady = 2'b00;
    if (ReqValid == 2'b11) begin
      grant = ~lastGrant;
    end else begin
      grant = ReqValid[1];
    end
    selA      = grant ? ReqA1  : ReqA0;
    selB      = grant ? ReqB1  : ReqB0;
    selOp     = grant ? ReqOp1 : ReqOp0;
    illegalOp = int'(selOp) >= NUM_OPS;
    if (state == IDLE && anyValid) begin
      ReqReady = grant ? 2'b10 : 2'b01;
    end
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (anyValid) nextState = EXEC;
      EXEC:    nextState = RESP;
      RESP:    if (RspValid && RspReady) nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      state <= nextState;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      AluA       <= '0;
      AluB       <= '0;
      AluControl <= '0;
      Result     <= '0;
      Zero       <= 1'b0;
      RspErr     <= 1'b0;
      RspId      <= 1'b0;
      RspValid   <= 1'b0;
      err        <= 1'b0;
      lastGrant  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (anyValid) begin
            AluA       <= selA;
            AluB       <= selB;
            // An illegal opcode still runs a harmless ADD and completes with an error tag.
            AluControl <= illegalOp ? 3'd0 : selOp;
            err        <= illegalOp;
            RspId      <= grant;
          end
        end
        EXEC: begin
          Result   <= err ? '0 : AluResult;
          Zero     <= err ? 1'b1 : AluZero;
          RspErr   <= err;
          RspValid <= 1'b1;
        end
        RESP: begin
          if (RspValid && RspReady) begin
            RspValid  <= 1'b0;
            lastGrant <= RspId;
          end
        end
        default: ;
      endcase
    end
  end

  assign Busy = (state != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter; a small behavioural ALU stands in for the
// external ALU instance so results flow back through the arbiter.
module tb_alu_arbiter;

  localparam int WIDTH = 32;

  logic             clk;
  logic             rst_n;
  logic [1:0]       ReqValid;
  logic [1:0]       ReqReady;
  logic [WIDTH-1:0] ReqA0, ReqB0, ReqA1, ReqB1;
  logic [2:0]       ReqOp0, ReqOp1;
  logic [WIDTH-1:0] AluA, AluB;
  logic [2:0]       AluControl;
  logic [WIDTH-1:0] AluResult;
  logic             AluZero;
  logic             RspValid;
  logic             RspReady;
  logic             RspId;
  logic [WIDTH-1:0] Result;
  logic             Zero;
  logic             RspErr;
  logic             Busy;

  int errors = 0;
  int checks = 0;

  alu_arbiter #(.WIDTH(WIDTH), .NUM_OPS(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .ReqValid(ReqValid), .ReqReady(ReqReady),
    .ReqA0(ReqA0), .ReqB0(ReqB0), .ReqOp0(ReqOp0),
    .ReqA1(ReqA1), .ReqB1(ReqB1), .ReqOp1(ReqOp1),
    .AluA(AluA), .AluB(AluB), .AluControl(AluControl),
    .AluResult(AluResult), .AluZero(AluZero),
    .RspValid(RspValid), .RspReady(RspReady), .RspId(RspId),
    .Result(Result), .Zero(Zero), .RspErr(RspErr), .Busy(Busy)
  );

  // External ALU: 000 ADD, 001 AND, 010 OR, 011 XOR.
  always_comb begin
    case (AluControl)
      3'd0:    AluResult = AluA + AluB;
      3'd1:    AluResult = AluA & AluB;
      3'd2:    AluResult = AluA | AluB;
      3'd3:    AluResult = AluA ^ AluB;
      default: AluResult = '0;
    endcase
    AluZero = (AluResult == '0);
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; ReqValid = 2'b00; RspReady = 1'b0;
    ReqA0 = '0; ReqB0 = '0; ReqOp0 = '0; ReqA1 = '0; ReqB1 = '0; ReqOp1 = '0;
    tick; tick;
    checks++; if ({AluA, AluB, AluControl} !== '0) begin errors++; $display("FAIL reset_alu_regs: got %h/%h/%h want 0", AluA, AluB, AluControl); end
    checks++; if ({Result, Zero, RspErr, RspId, RspValid} !== '0) begin errors++; $display("FAIL reset_rsp_regs: got res=%h z=%b err=%b id=%b v=%b want all 0", Result, Zero, RspErr, RspId, RspValid); end
    checks++; if ({Busy, ReqReady} !== 3'b000) begin errors++; $display("FAIL reset_busy_ready: got busy=%b ready=%b want 0/00", Busy, ReqReady); end
    rst_n = 1'b1;
    tick;
  endtask

  task automatic test_single_req0;
    ReqValid = 2'b01; ReqA0 = 32'h5; ReqB0 = 32'hA; ReqOp0 = 3'b000; RspReady = 1'b1;
    #1;
    checks++; if (ReqReady !== 2'b01) begin errors++; $display("FAIL r0_ready: got %b want 01", ReqReady); end
    tick; ReqValid = 2'b00;
    checks++; if ({ReqReady, Busy, RspValid} !== 4'b0010) begin errors++; $display("FAIL r0_exec: got ready=%b busy=%b v=%b want 00/1/0", ReqReady, Busy, RspValid); end
    tick;
    checks++; if ({RspValid, Result, Zero, RspId, RspErr} !== {1'b1, 32'h0000000F, 3'b000}) begin errors++; $display("FAIL r0_rsp: got v=%b res=%h z=%b id=%b err=%b want 1/0000000f/0/0/0", RspValid, Result, Zero, RspId, RspErr); end
    tick;
    checks++; if ({RspValid, Busy} !== 2'b00) begin errors++; $display("FAIL r0_done: got v=%b busy=%b want 0/0", RspValid, Busy); end
  endtask

  task automatic test_single_req1_and;
    ReqValid = 2'b10; ReqA1 = 32'hF0; ReqB1 = 32'h0F; ReqOp1 = 3'b001; RspReady = 1'b1;
    #1;
    checks++; if (ReqReady !== 2'b10) begin errors++; $display("FAIL r1_ready: got %b want 10", ReqReady); end
    tick; ReqValid = 2'b00;
    checks++; if ({AluControl, AluA, AluB} !== {3'b001, 32'hF0, 32'h0F}) begin errors++; $display("FAIL r1_alu_in: got ctl=%b a=%h b=%h want 001/f0/0f", AluControl, AluA, AluB); end
    tick;
    checks++; if ({RspValid, Result, Zero, RspId, RspErr} !== {1'b1, 32'h0, 1'b1, 1'b1, 1'b0}) begin errors++; $display("FAIL r1_rsp: got v=%b res=%h z=%b id=%b err=%b want 1/0/1/1/0", RspValid, Result, Zero, RspId, RspErr); end
    tick;
  endtask

  task automatic test_back_to_back;
    int nGrant = 0;
    logic [3:0] grants = '0;
    int cycles [4];
    ReqValid = 2'b11; RspReady = 1'b1;
    ReqA0 = 32'h1;  ReqB0 = 32'h2;  ReqOp0 = 3'b000;
    ReqA1 = 32'h10; ReqB1 = 32'h20; ReqOp1 = 3'b010;
    #1;
    for (int cyc = 0; cyc < 12; cyc++) begin
      checks++; if (ReqReady === 2'b11) begin errors++; $display("FAIL b2b_onehot: cycle %0d got ready=11 want at most one bit", cyc); end
      if (ReqReady != 2'b00 && nGrant < 4) begin
        grants[nGrant] = ReqReady[1];
        cycles[nGrant] = cyc;
        nGrant++;
      end
      if (RspValid) begin
        checks++; if (Result !== (RspId ? 32'h30 : 32'h3)) begin errors++; $display("FAIL b2b_result: cycle %0d id=%b got %h want %h", cyc, RspId, Result, RspId ? 32'h30 : 32'h3); end
      end
      tick;
    end
    ReqValid = 2'b00;
    checks++; if (nGrant !== 4) begin errors++; $display("FAIL b2b_count: got %0d grants want 4", nGrant); end
    checks++; if (grants !== 4'b1010) begin errors++; $display("FAIL b2b_order: got grant bits (3..0) %b want 1010", grants); end
    checks++; if (cycles[1] - cycles[0] !== 3 || cycles[2] - cycles[1] !== 3 || cycles[3] - cycles[2] !== 3) begin errors++; $display("FAIL b2b_spacing: got accept cycles %0d %0d %0d %0d want spacing 3", cycles[0], cycles[1], cycles[2], cycles[3]); end
    tick;
  endtask

  task automatic test_hold_response;
    ReqValid = 2'b01; ReqA0 = 32'hFFFF0000; ReqB0 = 32'h0000FFFF; ReqOp0 = 3'b011; RspReady = 1'b0;
    tick;
    ReqValid = 2'b10; ReqA1 = 32'h0; ReqB1 = 32'h0; ReqOp1 = 3'b000;
    tick;
    for (int i = 0; i < 5; i++) begin
      checks++; if ({RspValid, Result, RspId, ReqReady, Busy} !== {1'b1, 32'hFFFFFFFF, 1'b0, 2'b00, 1'b1}) begin errors++; $display("FAIL hold_%0d: got v=%b res=%h id=%b ready=%b busy=%b want 1/ffffffff/0/00/1", i, RspValid, Result, RspId, ReqReady, Busy); end
      if (i < 4) tick;
    end
    RspReady = 1'b1;
    tick;
    checks++; if ({Busy, RspValid, ReqReady} !== 4'b0010) begin errors++; $display("FAIL hold_release: got busy=%b v=%b ready=%b want 0/0/10", Busy, RspValid, ReqReady); end
    tick; ReqValid = 2'b00;
    tick;
    checks++; if ({RspValid, Result, Zero, RspId} !== {1'b1, 32'h0, 1'b1, 1'b1}) begin errors++; $display("FAIL hold_next: got v=%b res=%h z=%b id=%b want 1/0/1/1", RspValid, Result, Zero, RspId); end
    tick;
  endtask

  task automatic test_illegal_op;
    ReqValid = 2'b01; ReqA0 = 32'h3; ReqB0 = 32'h3; ReqOp0 = 3'b101; RspReady = 1'b1;
    #1;
    tick; ReqValid = 2'b00;
    checks++; if ({AluControl, AluA} !== {3'b000, 32'h3}) begin errors++; $display("FAIL illegal_ctl: got ctl=%b a=%h want 000/3", AluControl, AluA); end
    tick;
    checks++; if ({RspValid, RspErr, Result, Zero, RspId} !== {2'b11, 32'h0, 1'b1, 1'b0}) begin errors++; $display("FAIL illegal_rsp: got v=%b err=%b res=%h z=%b id=%b want 1/1/0/1/0", RspValid, RspErr, Result, Zero, RspId); end
    tick;
  endtask

  task automatic test_reset_mid_exec;
    ReqValid = 2'b10; ReqA1 = 32'h7; ReqB1 = 32'h8; ReqOp1 = 3'b000; RspReady = 1'b1;
    tick; ReqValid = 2'b00;
    checks++; if ({Busy, AluA, RspId} !== {1'b1, 32'h7, 1'b1}) begin errors++; $display("FAIL rst_pre: got busy=%b a=%h id=%b want 1/7/1", Busy, AluA, RspId); end
    #2; rst_n = 1'b0; #1;
    checks++; if ({AluA, AluB, AluControl, Result, Zero, RspErr, RspId, RspValid, Busy} !== '0) begin errors++; $display("FAIL rst_async: got a=%h b=%h ctl=%b res=%h z=%b err=%b id=%b v=%b busy=%b want all 0", AluA, AluB, AluControl, Result, Zero, RspErr, RspId, RspValid, Busy); end
    tick; rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick;
      checks++; if ({RspValid, Busy} !== 2'b00) begin errors++; $display("FAIL rst_no_rsp_%0d: got v=%b busy=%b want 0/0", i, RspValid, Busy); end
    end
    ReqValid = 2'b11; ReqA0 = 32'h100; ReqB0 = 32'h23; ReqOp0 = 3'b000;
    #1;
    checks++; if (ReqReady !== 2'b01) begin errors++; $display("FAIL rst_tiebreak: got ready=%b want 01", ReqReady); end
    tick; ReqValid = 2'b00;
    tick;
    checks++; if ({RspValid, RspId, Result} !== {2'b10, 32'h123}) begin errors++; $display("FAIL rst_after: got v=%b id=%b res=%h want 1/0/123", RspValid, RspId, Result); end
    tick;
  endtask

  initial begin
    test_reset;
    test_single_req0;
    test_single_req1_and;
    test_back_to_back;
    test_hold_response;
    test_illegal_op;
    test_reset_mid_exec;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
